// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Optional fetch-address fault detection is enabled by defining FETCH_BOUND_CHECK_EN.
module instr_fetch #(
   parameter logic [15:0]   RESET_PC    = 16'h0000,
   parameter int unsigned   ROM_WORDS   = 16,
   parameter logic [3:0]    HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_target,
   output logic [15:0] pc,
   input  logic [15:0] instr_in,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic        ifid_valid,
   output logic        halted,
   output logic        fault
);

   localparam int unsigned PC_W      = 16;
   localparam int unsigned ROM_BYTES = 2 * ROM_WORDS;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1
`ifdef FETCH_BOUND_CHECK_EN
      ,
      S_FAULT = 2'd2
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   ifid_instr_q, ifid_instr_d;
   logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic              halted_q, halted_d;

`ifdef FETCH_BOUND_CHECK_EN
   logic              fault_q, fault_d;
   logic              bad_addr_c;

   // Address lies outside the ROM or is not halfword aligned.
   assign bad_addr_c = (32'(pc_q) >= ROM_BYTES) || pc_q[0];
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_RUN;
         pc_q         <= RESET_PC;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         halted_q     <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         halted_q     <= halted_d;
`ifdef FETCH_BOUND_CHECK_EN
         fault_q      <= fault_d;
`endif
      end
   end

   // Next-state logic; everything holds unless a rule below fires.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      halted_d     = halted_q;
`ifdef FETCH_BOUND_CHECK_EN
      fault_d      = fault_q;
`endif
      unique case (state_q)
         S_RUN: begin
            if (redirect_valid) begin
               pc_d         = redirect_target;
               ifid_valid_d = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
            end else if (bad_addr_c) begin
               fault_d      = 1'b1;
               ifid_valid_d = 1'b0;
               state_d      = S_FAULT;
`endif
            end else if (!stall) begin
               ifid_instr_d = instr_in;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
               if (instr_in[15:12] == HALT_OPCODE) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end else begin
                  pc_d = pc_q + PC_W'(2);
               end
            end
         end
         // The HALT word stays valid while decode is stalled, then retires.
         S_HALT: begin
            if (!stall) begin
               ifid_valid_d = 1'b0;
            end
         end
`ifdef FETCH_BOUND_CHECK_EN
         S_FAULT: begin
            ifid_valid_d = 1'b0;
         end
`endif
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   assign pc         = pc_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign halted     = halted_q;
`ifdef FETCH_BOUND_CHECK_EN
   assign fault      = fault_q;
`else
   assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a rule-level fetch model and a ROM array.
// Honours FETCH_BOUND_CHECK_EN the same way as the design.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic [15:0] pc;
   logic [15:0] instr_in;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic        ifid_valid;
   logic        halted;
   logic        fault;

   logic [15:0] rom [16];

   int n_vec  = 0;
   int n_miss = 0;

   // Reference state: mode 0 = fetching, 1 = halted, 2 = faulted.
   int          m_mode;
   logic [15:0] m_pc, m_instr, m_ipc;
   logic        m_valid, m_halted, m_fault;

   instr_fetch #(
      .RESET_PC   (16'h0000),
      .ROM_WORDS  (16),
      .HALT_OPCODE(4'hF)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .pc             (pc),
      .instr_in       (instr_in),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid),
      .halted         (halted),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instr_in = rom[pc[4:1]];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("pc",         pc,                 m_pc);
      check("ifid_instr", ifid_instr,         m_instr);
      check("ifid_pc",    ifid_pc,            m_ipc);
      check("ifid_valid", 16'(ifid_valid),    16'(m_valid));
      check("halted",     16'(halted),        16'(m_halted));
      check("fault",      16'(fault),         16'(m_fault));
   endtask

   function automatic bit addr_bad(input logic [15:0] a);
`ifdef FETCH_BOUND_CHECK_EN
      return (a >= 16'd32) || a[0];
`else
      return 1'b0;
`endif
   endfunction

   // Apply the fetch rules for one rising edge, using the inputs about to be sampled.
   task automatic model_edge();
      logic [15:0] word;
      if (!rst_n) begin
         m_mode = 0; m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
         m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
      end else if (m_mode == 0) begin
         if (redirect_valid) begin
            m_pc = redirect_target;
            m_valid = 1'b0;
         end else if (addr_bad(m_pc)) begin
            m_fault = 1'b1; m_valid = 1'b0; m_mode = 2;
         end else if (!stall) begin
            word    = rom[m_pc[4:1]];
            m_instr = word;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            if (word[15:12] == 4'hF) begin
               m_halted = 1'b1; m_mode = 1;
            end else begin
               m_pc = m_pc + 16'd2;
            end
         end
      end else if (m_mode == 1) begin
         if (!stall) m_valid = 1'b0;
      end
   endtask

   task automatic step(input logic rn, input logic st, input logic rv, input logic [15:0] rt);
      rst_n = rn; stall = st; redirect_valid = rv; redirect_target = rt;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic fill_plain_rom();
      for (int i = 0; i < 16; i++) rom[i] = 16'h1000 | 16'(i + 1);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
      fill_plain_rom();
      m_mode = 0; m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;

      // Sequential fetch, stall, redirect under stall, then HALT.
      rom[3] = 16'hF000;
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("rst_pc", pc, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("seq_pc4", pc, 16'h0004);
      check("seq_instr2", ifid_instr, 16'h1002);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
      check("stall_instr", ifid_instr, 16'h1002);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("resume_instr", ifid_instr, 16'h1003);
      check("resume_ipc", ifid_pc, 16'h0004);
      step(1'b1, 1'b1, 1'b1, 16'h0010);
      check("redir_pc", pc, 16'h0010);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("redir_ipc", ifid_pc, 16'h0010);
      step(1'b1, 1'b0, 1'b1, 16'h0006);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("halt_instr", ifid_instr, 16'hF000);
      check("halt_flag", 16'(halted), 16'h0001);
      step(1'b1, 1'b0, 1'b1, 16'h0000);
      check("halt_pc", pc, 16'h0006);
      check("halt_valid", 16'(ifid_valid), 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("halt_rst", 16'(halted), 16'h0000);

      // Run off the end of the ROM, then wrap 0xFFFE.
      fill_plain_rom();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
      check("end_pc", pc, 16'h0020);
      step(1'b1, 1'b0, 1'b0, 16'h0);
`ifdef FETCH_BOUND_CHECK_EN
      check("oob_fault", 16'(fault), 16'h0001);
      check("oob_pc", pc, 16'h0020);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("oob_rst", 16'(fault), 16'h0000);
      step(1'b1, 1'b0, 1'b1, 16'h0003);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("odd_fault", 16'(fault), 16'h0001);
      check("odd_pc", pc, 16'h0003);
      step(1'b0, 1'b0, 1'b0, 16'h0);
`else
      check("alias_instr", ifid_instr, 16'h1001);
      check("alias_fault", 16'(fault), 16'h0000);
      step(1'b1, 1'b0, 1'b1, 16'hFFFE);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      check("wrap_pc", pc, 16'h0000);
`endif

      // Random traffic against the model, reloading the ROM on each reset.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic       rn, st, rv;
         logic [15:0] rt;
         rn = ($urandom_range(0, 59) != 0);
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       rt = 16'($urandom);
            1:       rt = 16'($urandom_range(0, 31)) | 16'h0001;
            default: rt = 16'($urandom_range(0, 15)) << 1;
         endcase
         if (!rn) begin
            for (int i = 0; i < 16; i++)
               rom[i] = ($urandom_range(0, 24) == 0) ? (16'hF000 | 16'($urandom_range(0, 4095)))
                                                       : (16'($urandom) & 16'hEFFF);
         end
         step(rn, st, rv, rt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
